joy_serial_mp: RTL and testbench

Parametrised serial-joystick reader for the UserIO port. It drives a daisy-chained 74HC165-style shift-register chain with load and clock strobes, and deserialises one frame carrying PLAYERS×BITS button bits. It debounces each bit across frames and presents active-high per-player button words in the system clock domain. It succeeds the fixed two-player DB15 reader and feeds the core's joystick mux in place of JOYDB15_1/2.

---
 rtl/joy_serial_pkg.sv | 25 ++
 rtl/joy_debounce.sv | 39 +++
 rtl/joy_serial_mp.sv | 138 +++++++++++++
 tb/tb_joy_serial_mp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/joy_serial_pkg.sv
// Shared types and sizing helpers for the serial joystick chain reader.
package joy_serial_pkg;

    // GAP idle | HALT wait for enable | LOAD parallel load | SHIFT clock bits | COMMIT publish
    typedef enum logic [2:0] {
        S_GAP    = 3'd0,
        S_HALT   = 3'd1,
        S_LOAD   = 3'd2,
        S_SHIFT  = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    function automatic int frame_bits(input int players, input int bits);
        return players * bits;
    endfunction

    function automatic int cnt_w(input int n_values);
        return (n_values < 2) ? 1 : $clog2(n_values);
    endfunction

    function automatic int flat_idx(input int player, input int bit_i, input int bits);
        return player * bits + bit_i;
    endfunction

endpackage

// File: rtl/joy_debounce.sv
// Per-bit frame debounce: an output bit follows raw only after DEBOUNCE
// consecutive committed frames disagree with it.
module joy_debounce #(
    parameter int WIDTH    = 24,
    parameter int DEBOUNCE = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_commit,
    input  logic [WIDTH-1:0] i_raw,
    output logic [WIDTH-1:0] o_joy
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0]    r_cnt [WIDTH];
    logic [WIDTH-1:0] r_joy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_joy <= '0;
            for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
        end else if (i_commit) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (i_raw[i] == r_joy[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CW'(DEBOUNCE - 1)) begin
                    r_joy[i] <= i_raw[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign o_joy = r_joy;

endmodule

// File: rtl/joy_serial_mp.sv
// Serial joystick chain reader: strobes a 74HC165-style chain, deserialises
// PLAYERS*BITS active-low buttons and publishes debounced active-high words.
module joy_serial_mp
    import joy_serial_pkg::*;
#(
    parameter int PLAYERS   = 2,
    parameter int BITS      = 12,
    parameter int CLK_DIV   = 8,
    parameter int DEBOUNCE  = 2,
    parameter int FRAME_GAP = 256
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic                      joy_data,
    output logic                      joy_load,
    output logic                      joy_clk,
    output logic [PLAYERS*BITS-1:0]   joystick,
    output logic                      frame_stb
);

    localparam int N  = frame_bits(PLAYERS, BITS);
    localparam int TW = cnt_w(CLK_DIV);
    localparam int GW = cnt_w(FRAME_GAP);
    localparam int IW = cnt_w(N);

    state_t        r_state, w_state_nxt;
    logic [1:0]    r_sync;
    logic [TW-1:0] r_tick, w_tick_nxt;
    logic [GW-1:0] r_gap, w_gap_nxt;
    logic [IW-1:0] r_idx, w_idx_nxt;
    logic          r_phase, w_phase_nxt;
    logic [N-1:0]  r_raw;
    logic          r_joy_load, r_joy_clk, r_frame_stb;
    logic          w_tick, w_gap_last, w_idx_last, w_capture, w_commit;

    assign w_tick     = (r_tick == TW'(CLK_DIV - 1));
    assign w_gap_last = (r_gap == GW'(FRAME_GAP - 1));
    assign w_idx_last = (r_idx == IW'(flat_idx(PLAYERS - 1, BITS - 1, BITS)));

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_idx_nxt   = r_idx;
        w_capture   = 1'b0;
        w_commit    = 1'b0;
        unique case (r_state)
            S_GAP: begin
                w_phase_nxt = 1'b0;
                if (w_gap_last) w_state_nxt = enable ? S_LOAD : S_HALT;
            end
            S_HALT: begin
                w_phase_nxt = 1'b0;
                if (enable) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_tick) begin
                    if (r_phase) begin
                        w_state_nxt = S_SHIFT;
                        w_phase_nxt = 1'b0;
                        w_idx_nxt   = '0;
                    end else begin
                        w_phase_nxt = 1'b1;
                    end
                end
            end
            S_SHIFT: begin
                // phase 0 holds joy_clk low and samples; phase 1 raises it to advance the chain
                if (w_tick) begin
                    if (!r_phase) begin
                        w_capture   = 1'b1;
                        w_phase_nxt = 1'b1;
                    end else begin
                        w_phase_nxt = 1'b0;
                        if (w_idx_last) w_state_nxt = S_COMMIT;
                        else            w_idx_nxt   = r_idx + IW'(1);
                    end
                end
            end
            S_COMMIT: begin
                w_commit    = 1'b1;
                w_state_nxt = S_GAP;
            end
            default: w_state_nxt = S_GAP;
        endcase

        w_tick_nxt = '0;
        if ((r_state == S_LOAD || r_state == S_SHIFT) && w_state_nxt == r_state)
            w_tick_nxt = w_tick ? '0 : r_tick + TW'(1);

        w_gap_nxt = '0;
        if (r_state == S_GAP && !w_gap_last)
            w_gap_nxt = r_gap + GW'(1);
    end

    // Strobe outputs are registered from next-state so the pins never glitch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_GAP;
            r_sync      <= '0;
            r_tick      <= '0;
            r_gap       <= '0;
            r_idx       <= '0;
            r_phase     <= 1'b0;
            r_raw       <= '0;
            r_joy_load  <= 1'b1;
            r_joy_clk   <= 1'b0;
            r_frame_stb <= 1'b0;
        end else begin
            r_sync      <= {r_sync[0], joy_data};
            r_state     <= w_state_nxt;
            r_tick      <= w_tick_nxt;
            r_gap       <= w_gap_nxt;
            r_idx       <= w_idx_nxt;
            r_phase     <= w_phase_nxt;
            r_joy_load  <= (w_state_nxt != S_LOAD);
            r_joy_clk   <= (w_state_nxt == S_SHIFT) && w_phase_nxt;
            r_frame_stb <= w_commit;
            if (w_capture) r_raw[r_idx] <= ~r_sync[1];
        end
    end

    joy_debounce #(
        .WIDTH    (N),
        .DEBOUNCE (DEBOUNCE)
    ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_commit (w_commit),
        .i_raw    (r_raw),
        .o_joy    (joystick)
    );

    assign joy_load  = r_joy_load;
    assign joy_clk   = r_joy_clk;
    assign frame_stb = r_frame_stb;

endmodule

// File: tb/tb_joy_serial_mp.sv
// Bench for joy_serial_mp: three configurations, each fed by a behavioural
// 74HC165 chain, checked against a frame-level debounce model.
module tb_joy_serial_mp;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic        reset_n;
    logic        en1, en2, en3;
    logic        d1, d2, d3, l1, l2, l3, c1, c2, c3, s1, s2, s3;
    logic [23:0] j1, j2;
    logic [15:0] j3;
    logic [23:0] pat1, pat2;
    logic [15:0] pat3;
    logic [23:0] sh1 = '1;
    logic [23:0] sh2 = '1;
    logic [15:0] sh3 = '1;

    joy_serial_mp #(.PLAYERS(2), .BITS(12), .CLK_DIV(8), .DEBOUNCE(1), .FRAME_GAP(256)) u_d1 (
        .clk(clk), .reset_n(reset_n), .enable(en1), .joy_data(d1),
        .joy_load(l1), .joy_clk(c1), .joystick(j1), .frame_stb(s1));

    joy_serial_mp u_d2 (
        .clk(clk), .reset_n(reset_n), .enable(en2), .joy_data(d2),
        .joy_load(l2), .joy_clk(c2), .joystick(j2), .frame_stb(s2));

    joy_serial_mp #(.PLAYERS(1), .BITS(16), .CLK_DIV(4), .DEBOUNCE(1), .FRAME_GAP(256)) u_d3 (
        .clk(clk), .reset_n(reset_n), .enable(en3), .joy_data(d3),
        .joy_load(l3), .joy_clk(c3), .joystick(j3), .frame_stb(s3));

    // Chain: load presents active-low buttons, each joy_clk rise moves the next bit to the output.
    always @(negedge l1 or posedge c1) if (!l1) sh1 <= ~pat1; else sh1 <= {1'b1, sh1[23:1]};
    always @(negedge l2 or posedge c2) if (!l2) sh2 <= ~pat2; else sh2 <= {1'b1, sh2[23:1]};
    always @(negedge l3 or posedge c3) if (!l3) sh3 <= ~pat3; else sh3 <= {1'b1, sh3[15:1]};
    assign d1 = sh1[0];
    assign d2 = sh2[0];
    assign d3 = sh3[0];

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] m_out [3];
    int          m_run [3][32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 3; s++) begin
            m_out[s] = '0;
            for (int b = 0; b < 32; b++) m_run[s][b] = 0;
        end
    endtask

    // A bit follows the pressed state once it has disagreed for deb frames in a row.
    task automatic model_frame(input int s, input logic [31:0] pressed, input int width, input int deb);
        for (int b = 0; b < width; b++) begin
            if (pressed[b] == m_out[s][b]) begin
                m_run[s][b] = 0;
            end else begin
                m_run[s][b] = m_run[s][b] + 1;
                if (m_run[s][b] >= deb) begin
                    m_out[s][b] = pressed[b];
                    m_run[s][b] = 0;
                end
            end
        end
    endtask

    function automatic logic stb_of(input int s);
        case (s)
            0:       return s1;
            1:       return s2;
            default: return s3;
        endcase
    endfunction

    task automatic wait_stb(input int s, input int budget, output int cyc);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
        end while (!stb_of(s) && cyc < budget);
        check($sformatf("stb_seen_%0d", s), 32'(stb_of(s)), 32'd1);
    endtask

    task automatic wait_rises(input int n, input int budget);
        int   r;
        int   cyc;
        logic p;
        r = 0; cyc = 0; p = c1;
        while (r < n && cyc < budget) begin
            @(posedge clk); #1;
            cyc++;
            if (c1 && !p) r++;
            p = c1;
        end
        check("rises_reached", 32'(r), 32'(n));
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, nrise, last, bad, nload, nstb;
        logic        prevc;
        logic [23:0] seq2 [5];

        seq2[0] = 24'h000000; seq2[1] = 24'h000010; seq2[2] = 24'h000000;
        seq2[3] = 24'h000010; seq2[4] = 24'h000010;

        reset_n = 1'b0;
        en1 = 1'b1; en2 = 1'b0; en3 = 1'b0;
        pat1 = 24'h800005; pat2 = '0; pat3 = 16'hA5C3;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_load", 32'(l1), 32'd1);
        check("rst_clk", 32'(c1), 32'd0);
        check("rst_joy", 32'(j1), 32'd0);
        check("rst_stb", 32'(s1), 32'd0);

        @(negedge clk) reset_n = 1'b1;
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (l1 && cyc < 400);
        check("first_load_fall", 32'(cyc), 32'd256);

        // First frame: count joy_clk rises and their spacing.
        nrise = 0; last = -1; bad = 0; prevc = c1;
        while (!s1 && cyc < 1000) begin
            @(posedge clk); #1;
            cyc++;
            if (c1 && !prevc) begin
                nrise++;
                if (last >= 0 && cyc - last != 16) bad++;
                last = cyc;
            end
            prevc = c1;
        end
        check("frame1_stb", 32'(s1), 32'd1);
        check("frame1_latency", 32'(cyc), 32'd657);
        check("frame1_rises", 32'(nrise), 32'd24);
        check("frame1_spacing", 32'(bad), 32'd0);
        model_frame(0, 32'(pat1), 24, 1);
        check("frame1_joy", 32'(j1), 32'h800005);
        check("frame1_joy_model", 32'(j1), m_out[0]);

        pat1 = 24'($urandom);
        @(posedge clk); #1;
        check("stb_one_cycle", 32'(s1), 32'd0);
        wait_stb(0, 800, cyc);
        check("period_d1", 32'(cyc + 1), 32'd657);
        model_frame(0, 32'(pat1), 24, 1);
        check("d1_joy_rand0", 32'(j1), m_out[0]);

        for (int k = 1; k < 5; k++) begin
            pat1 = 24'($urandom);
            wait_stb(0, 800, cyc);
            model_frame(0, 32'(pat1), 24, 1);
            check($sformatf("d1_joy_rand%0d", k), 32'(j1), m_out[0]);
        end

        // Dropping enable mid-SHIFT lets the frame finish, then stalls.
        pat1 = 24'($urandom) | 24'h1;
        wait_rises(3, 1000);
        @(negedge clk) en1 = 1'b0;
        wait_stb(0, 1000, cyc);
        model_frame(0, 32'(pat1), 24, 1);
        check("en_drop_joy", 32'(j1), m_out[0]);
        nload = 0; nstb = 0;
        repeat (5000) begin
            @(posedge clk); #1;
            if (!l1) nload++;
            if (s1) nstb++;
        end
        check("halt_no_load", 32'(nload), 32'd0);
        check("halt_no_stb", 32'(nstb), 32'd0);
        pat1 = 24'($urandom);
        @(negedge clk) en1 = 1'b1;
        @(posedge clk); #1;
        check("en_load_next", 32'(l1), 32'd0);
        wait_stb(0, 800, cyc);
        model_frame(0, 32'(pat1), 24, 1);
        check("en_resume_joy", 32'(j1), m_out[0]);

        // Reset during SHIFT at bit index 10.
        pat1 = 24'($urandom);
        wait_rises(10, 1000);
        repeat (10) @(posedge clk);
        @(negedge clk) reset_n = 1'b0;
        #1;
        check("midrst_load", 32'(l1), 32'd1);
        check("midrst_clk", 32'(c1), 32'd0);
        check("midrst_joy", 32'(j1), 32'd0);
        check("midrst_stb", 32'(s1), 32'd0);
        model_reset();
        repeat (3) @(posedge clk);
        pat1 = 24'($urandom);
        @(negedge clk) reset_n = 1'b1;
        wait_stb(0, 800, cyc);
        check("midrst_latency", 32'(cyc), 32'd657);
        model_frame(0, 32'(pat1), 24, 1);
        check("midrst_joy_after", 32'(j1), m_out[0]);

        // Default instance, DEBOUNCE=2.
        for (int k = 0; k < 10; k++) begin
            if (k < 5) pat2 = seq2[k];
            else if ($urandom_range(1, 0) == 1) pat2 = 24'($urandom);
            if (k == 0) @(negedge clk) en2 = 1'b1;
            wait_stb(1, 1000, cyc);
            model_frame(1, 32'(pat2), 24, 2);
            check($sformatf("d2_frame%0d", k), 32'(j2), m_out[1]);
            if (k == 1) check("d2_single_press", 32'(j2[4]), 32'd0);
            if (k == 3) check("d2_first_of_two", 32'(j2[4]), 32'd0);
            if (k == 4) check("d2_two_presses", 32'(j2[4]), 32'd1);
        end

        // One player, 16 bits, CLK_DIV=4.
        @(negedge clk) en3 = 1'b1;
        wait_stb(2, 600, cyc);
        model_frame(2, 32'(pat3), 16, 1);
        check("d3_a5c3", 32'(j3), 32'h0000A5C3);
        for (int k = 0; k < 3; k++) begin
            pat3 = 16'($urandom);
            wait_stb(2, 600, cyc);
            if (k == 0) check("d3_period", 32'(cyc), 32'd393);
            model_frame(2, 32'(pat3), 16, 1);
            check($sformatf("d3_rand%0d", k), 32'(j3), m_out[2]);
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
